// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: hazard sequencer states, the per-register
// stall/flush bundle, and default sizing constants.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FETCH_WAIT = 2'd1,
      MEM_WAIT   = 2'd2,
      HALT       = 2'd3
   } hazard_state_t;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
   } pipe_ctrl_t;

   localparam int MEM_TIMEOUT_DEFAULT = 255;
   localparam int CNT_W_DEFAULT       = 32;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: the load in EX writes a register that the ID instruction reads.
module hazard_detect (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       load_use
);

   // x0 is never a real dependency, so a load to it cannot create a hazard
   always_comb begin
      load_use = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline, with a data-memory
// timeout into HALT and saturating stall/flush performance counters.
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output hazard_state_t    state,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [WAIT_W-1:0] wait_cnt;
   pipe_ctrl_t        ctrl;
   logic              load_use;
   logic              data_wait;
   logic              timeout;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   assign data_wait = dmem_req && !dmem_ready;
   // The wait counter holds the cycles already spent; this cycle is the last allowed one
   assign timeout   = data_wait && (wait_cnt == WAIT_LAST);

   // Reset flushes every stage so nothing stale retires; otherwise the
   // highest-priority hazard alone decides this cycle's controls.
   always_comb begin
      ctrl = '0;
      if (reset) begin
         ctrl.if_id_flush  = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
         ctrl.mem_wb_flush = 1'b1;
      end else if (state == HALT) begin
         ctrl.pc_stall     = 1'b1;
         ctrl.if_id_stall  = 1'b1;
         ctrl.id_ex_stall  = 1'b1;
         ctrl.ex_mem_stall = 1'b1;
      end else if (data_wait) begin
         ctrl.pc_stall     = 1'b1;
         ctrl.if_id_stall  = 1'b1;
         ctrl.id_ex_stall  = 1'b1;
         ctrl.ex_mem_stall = 1'b1;
         ctrl.mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         ctrl.if_id_flush  = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
      end else if (load_use) begin
         ctrl.pc_stall     = 1'b1;
         ctrl.if_id_stall  = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
      end else if (!imem_ready) begin
         ctrl.pc_stall     = 1'b1;
         ctrl.if_id_flush  = 1'b1;
      end
   end

   assign pc_stall     = ctrl.pc_stall;
   assign if_id_stall  = ctrl.if_id_stall;
   assign id_ex_stall  = ctrl.id_ex_stall;
   assign ex_mem_stall = ctrl.ex_mem_stall;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_flush  = ctrl.id_ex_flush;
   assign mem_wb_flush = ctrl.mem_wb_flush;
   assign halted       = (state == HALT);

   // HALT is sticky until reset; a completing access in the timeout cycle wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (state == HALT || halt_req || timeout) begin
            state    <= HALT;
            wait_cnt <= '0;
         end else if (data_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= wait_cnt + WAIT_ONE;
         end else begin
            state    <= imem_ready ? RUN : FETCH_WAIT;
            wait_cnt <= '0;
         end

         if (ctrl.pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if ((ctrl.if_id_flush || ctrl.id_ex_flush) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus a
// randomized run against a cycle-level reference model.
module tb_pipeline_ctrl;
   import riscv_pkg::*;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
   logic          imem_ready, dmem_req, dmem_ready, halt_req;

   logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic          if_id_flush, id_ex_flush, mem_wb_flush;
   hazard_state_t state;
   logic          halted;
   logic [31:0]   stall_cnt, flush_cnt;

   logic          sm_pc_stall, sm_if_id_stall, sm_id_ex_stall, sm_ex_mem_stall;
   logic          sm_if_id_flush, sm_id_ex_flush, sm_mem_wb_flush;
   hazard_state_t sm_state;
   logic          sm_halted;
   logic [3:0]    sm_stall_cnt, sm_flush_cnt;

   logic [6:0]    ctrl_o, sm_ctrl_o;
   int            tests_run;
   int            tests_failed;

   assign ctrl_o    = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                       if_id_flush, id_ex_flush, mem_wb_flush};
   assign sm_ctrl_o = {sm_pc_stall, sm_if_id_stall, sm_id_ex_stall, sm_ex_mem_stall,
                       sm_if_id_flush, sm_id_ex_flush, sm_mem_wb_flush};

   pipeline_ctrl dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush), .state(state), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_stall(sm_pc_stall), .if_id_stall(sm_if_id_stall), .id_ex_stall(sm_id_ex_stall),
      .ex_mem_stall(sm_ex_mem_stall), .if_id_flush(sm_if_id_flush),
      .id_ex_flush(sm_id_ex_flush), .mem_wb_flush(sm_mem_wb_flush), .state(sm_state),
      .halted(sm_halted), .stall_cnt(sm_stall_cnt), .flush_cnt(sm_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after each rising edge; checks happen 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      reset       = 1'b0;
      id_rs1      = 5'd0;
      id_rs2      = 5'd0;
      id_use_rs1  = 1'b0;
      id_use_rs2  = 1'b0;
      ex_rd       = 5'd0;
      ex_mem_read = 1'b0;
      ex_redirect = 1'b0;
      imem_ready  = 1'b1;
      dmem_req    = 1'b0;
      dmem_ready  = 1'b0;
      halt_req    = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset       = 1'b1;
      ex_redirect = 1'b1;
      dmem_req    = 1'b1;
      imem_ready  = 1'b0;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000111) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl_o, 7'b0000111);
      end
      tick();
      tests_run++;
      if (state !== RUN || halted !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got state=%0d halted=%b stall=%0d flush=%0d expected 0 0 0 0",
                  state, halted, stall_cnt, flush_cnt);
      end
      drive_idle();
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000000) begin
         tests_failed++;
         $display("[TB] FAIL idle_ctrl: got %b expected %b", ctrl_o, 7'b0000000);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1;
      ex_rd       = 5'd5;
      id_rs1      = 5'd3;
      id_use_rs1  = 1'b1;
      id_rs2      = 5'd5;
      id_use_rs2  = 1'b1;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b1100010) begin
         tests_failed++;
         $display("[TB] FAIL load_use_ctrl: got %b expected %b", ctrl_o, 7'b1100010);
      end
      tick();
      ex_mem_read = 1'b0;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000000 || state !== RUN) begin
         tests_failed++;
         $display("[TB] FAIL load_use_release: got %b state=%0d expected %b state=0",
                  ctrl_o, state, 7'b0000000);
      end
      tests_run++;
      if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL load_use_counts: got stall=%0d flush=%0d expected 1 1", stall_cnt, flush_cnt);
      end
      ex_mem_read = 1'b1;
      ex_rd       = 5'd0;
      id_rs2      = 5'd0;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000000) begin
         tests_failed++;
         $display("[TB] FAIL load_use_x0: got %b expected %b", ctrl_o, 7'b0000000);
      end
      tick();
   endtask

   task automatic test_redirect_priority();
      do_reset();
      ex_mem_read = 1'b1;
      ex_rd       = 5'd9;
      id_rs1      = 5'd9;
      id_use_rs1  = 1'b1;
      ex_redirect = 1'b1;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000110) begin
         tests_failed++;
         $display("[TB] FAIL redirect_ctrl: got %b expected %b", ctrl_o, 7'b0000110);
      end
      tick();
      drive_idle();
      #2;
      tests_run++;
      if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0 || state !== RUN) begin
         tests_failed++;
         $display("[TB] FAIL redirect_counts: got flush=%0d stall=%0d state=%0d expected 1 0 0",
                  flush_cnt, stall_cnt, state);
      end
      tick();
   endtask

   task automatic test_data_wait();
      do_reset();
      ex_redirect = 1'b1;
      dmem_req    = 1'b1;
      dmem_ready  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         tests_run++;
         if (ctrl_o !== 7'b1111001) begin
            tests_failed++;
            $display("[TB] FAIL data_wait_ctrl[%0d]: got %b expected %b", c, ctrl_o, 7'b1111001);
         end
         tick();
         tests_run++;
         if (state !== MEM_WAIT) begin
            tests_failed++;
            $display("[TB] FAIL data_wait_state[%0d]: got %0d expected %0d", c, state, MEM_WAIT);
         end
      end
      dmem_ready = 1'b1;
      #2;
      tests_run++;
      if (ctrl_o !== 7'b0000110) begin
         tests_failed++;
         $display("[TB] FAIL data_wait_redirect: got %b expected %b", ctrl_o, 7'b0000110);
      end
      tick();
      drive_idle();
      #2;
      tests_run++;
      if (state !== RUN || stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL data_wait_end: got state=%0d stall=%0d flush=%0d expected 0 3 1",
                  state, stall_cnt, flush_cnt);
      end
      tick();
   endtask

   task automatic test_fetch_wait();
      do_reset();
      imem_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #2;
         tests_run++;
         if (ctrl_o !== 7'b1000100) begin
            tests_failed++;
            $display("[TB] FAIL fetch_wait_ctrl[%0d]: got %b expected %b", c, ctrl_o, 7'b1000100);
         end
         tick();
         tests_run++;
         if (state !== FETCH_WAIT) begin
            tests_failed++;
            $display("[TB] FAIL fetch_wait_state[%0d]: got %0d expected %0d", c, state, FETCH_WAIT);
         end
      end
      imem_ready = 1'b1;
      tick();
      tests_run++;
      if (state !== RUN || stall_cnt !== 32'd2 || flush_cnt !== 32'd2) begin
         tests_failed++;
         $display("[TB] FAIL fetch_wait_end: got state=%0d stall=%0d flush=%0d expected 0 2 2",
                  state, stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      dmem_req   = 1'b1;
      dmem_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         tests_run++;
         if (sm_halted !== (c == 4)) begin
            tests_failed++;
            $display("[TB] FAIL timeout_halted[%0d]: got %b expected %b", c, sm_halted, c == 4);
         end
      end
      #1;
      tests_run++;
      if (sm_ctrl_o !== 7'b1111000 || sm_state !== HALT) begin
         tests_failed++;
         $display("[TB] FAIL timeout_halt_ctrl: got %b state=%0d expected %b state=3",
                  sm_ctrl_o, sm_state, 7'b1111000);
      end
      dmem_req = 1'b0;
      tick();
      tests_run++;
      if (sm_halted !== 1'b1 || sm_ctrl_o !== 7'b1111000) begin
         tests_failed++;
         $display("[TB] FAIL timeout_sticky: got halted=%b ctrl=%b expected 1 %b",
                  sm_halted, sm_ctrl_o, 7'b1111000);
      end
      do_reset();
      tests_run++;
      if (sm_state !== RUN || sm_stall_cnt !== 4'd0 || sm_flush_cnt !== 4'd0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_reset: got state=%0d stall=%0d flush=%0d expected 0 0 0",
                  sm_state, sm_stall_cnt, sm_flush_cnt);
      end
      // Completion arriving in the final allowed cycle must beat the timeout
      dmem_req = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      dmem_ready = 1'b1;
      tick();
      tests_run++;
      if (sm_state !== RUN || sm_halted !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_race: got state=%0d halted=%b expected 0 0", sm_state, sm_halted);
      end
   endtask

   task automatic test_halt_req();
      do_reset();
      halt_req   = 1'b1;
      dmem_req   = 1'b1;
      dmem_ready = 1'b1;
      tick();
      drive_idle();
      #1;
      tests_run++;
      if (state !== HALT || halted !== 1'b1 || ctrl_o !== 7'b1111000) begin
         tests_failed++;
         $display("[TB] FAIL halt_req: got state=%0d halted=%b ctrl=%b expected 3 1 %b",
                  state, halted, ctrl_o, 7'b1111000);
      end
      tick();
      reset = 1'b1;
      #1;
      tests_run++;
      if (ctrl_o !== 7'b0000111) begin
         tests_failed++;
         $display("[TB] FAIL halt_reset_ctrl: got %b expected %b", ctrl_o, 7'b0000111);
      end
      tick();
      reset = 1'b0;
      tests_run++;
      if (state !== RUN || halted !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL halt_reset_state: got state=%0d halted=%b expected 0 0", state, halted);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      imem_ready = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      imem_ready = 1'b1;
      tests_run++;
      if (sm_stall_cnt !== 4'd15 || sm_flush_cnt !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL sat_small: got stall=%0d flush=%0d expected 15 15", sm_stall_cnt, sm_flush_cnt);
      end
      tests_run++;
      if (stall_cnt !== 32'd20 || flush_cnt !== 32'd20) begin
         tests_failed++;
         $display("[TB] FAIL sat_wide: got stall=%0d flush=%0d expected 20 20", stall_cnt, flush_cnt);
      end
   endtask

   // Reference model: state is "what the previous cycle looked like", and the
   // timeout is a plain count of consecutive unfinished data accesses.
   task automatic test_random();
      bit      m_halted = 1'b0;
      bit      m_prev_dwait = 1'b0;
      bit      m_prev_imiss = 1'b0;
      int      m_waits = 0;
      longint  m_stalls = 0;
      longint  m_flushes = 0;
      bit      lu, dw;
      logic [6:0]    exp_ctrl;
      hazard_state_t exp_state;
      logic [4:0]    src;
      bit            use_src;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset       = ($urandom_range(0, 39) == 0);
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         ex_rd       = 5'($urandom_range(0, 7));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 3) == 0);
         imem_ready  = ($urandom_range(0, 3) != 0);
         dmem_req    = ($urandom_range(0, 2) == 0);
         dmem_ready  = 1'($urandom_range(0, 1));
         halt_req    = ($urandom_range(0, 99) == 0);
         #2;
         lu = 1'b0;
         for (int k = 0; k < 2; k++) begin
            src     = (k == 0) ? id_rs1 : id_rs2;
            use_src = (k == 0) ? id_use_rs1 : id_use_rs2;
            if (ex_mem_read && ex_rd != 5'd0 && use_src && src == ex_rd) lu = 1'b1;
         end
         dw = dmem_req && !dmem_ready;
         if (reset)            exp_ctrl = 7'b0000111;
         else if (m_halted)    exp_ctrl = 7'b1111000;
         else if (dw)          exp_ctrl = 7'b1111001;
         else if (ex_redirect) exp_ctrl = 7'b0000110;
         else if (lu)          exp_ctrl = 7'b1100010;
         else if (!imem_ready) exp_ctrl = 7'b1000100;
         else                  exp_ctrl = 7'b0000000;
         exp_state = m_halted ? HALT : m_prev_dwait ? MEM_WAIT : m_prev_imiss ? FETCH_WAIT : RUN;
         tests_run++;
         if (ctrl_o !== exp_ctrl) begin
            tests_failed++;
            $display("[TB] FAIL rand_ctrl[%0d]: got %b expected %b", i, ctrl_o, exp_ctrl);
         end
         tests_run++;
         if (state !== exp_state || halted !== m_halted) begin
            tests_failed++;
            $display("[TB] FAIL rand_state[%0d]: got %0d/%b expected %0d/%b",
                     i, state, halted, exp_state, m_halted);
         end
         tests_run++;
         if (stall_cnt !== 32'(m_stalls) || flush_cnt !== 32'(m_flushes)) begin
            tests_failed++;
            $display("[TB] FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d",
                     i, stall_cnt, flush_cnt, m_stalls, m_flushes);
         end
         tick();
         if (reset) begin
            m_halted = 1'b0; m_prev_dwait = 1'b0; m_prev_imiss = 1'b0;
            m_waits = 0; m_stalls = 0; m_flushes = 0;
         end else begin
            if (exp_ctrl[6]) m_stalls++;
            if (exp_ctrl[2] || exp_ctrl[1]) m_flushes++;
            if (!m_halted) begin
               if (dw) m_waits++;
               else m_waits = 0;
               if (halt_req || m_waits >= MEM_TIMEOUT_DEFAULT) m_halted = 1'b1;
            end
            m_prev_dwait = dw;
            m_prev_imiss = !imem_ready;
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      drive_idle();
      test_reset();
      test_load_use();
      test_redirect_priority();
      test_data_wait();
      test_fetch_wait();
      test_timeout();
      test_halt_req();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable. Resolves load-use hazards, EX-stage redirects, instruction- and data-memory wait states, and a halt/timeout condition. Maintains saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before entering HALT.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/jump or mispredict
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage has an access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  external/debug halt request
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each
- state  out  2  current hazard_state_t
- halted  out  1  state == HALT
- stall_cnt, flush_cnt  out  CNT_W each  saturating cycle counters

## Operation
- States: RUN, FETCH_WAIT, MEM_WAIT, HALT. The state register is the only control storage. Outputs are combinational from the state and inputs.
- Load-use: `ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))`.
- Per-cycle priority, highest first:
  1. HALT
  2. Data wait: `dmem_req && !dmem_ready`
  3. ex_redirect
  4. Load-use
  5. Fetch wait: `!imem_ready`
- HALT: all four stalls = 1, all flushes = 0. Only reset exits HALT.
- Data wait:
  - pc/if_id/id_ex/ex_mem stall = 1; mem_wb_flush = 1.
  - ex_redirect and load-use are ignored. They stay asserted because EX is frozen, and are acted on after the wait ends.
  - State = MEM_WAIT; the wait counter increments.
- Redirect: if_id_flush = 1 and id_ex_flush = 1. No stalls; the PC loads the target.
- Load-use: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 for exactly one cycle. Whether the hazard repeats next cycle is decided by the compare alone.
- Fetch wait: pc_stall = 1 and if_id_flush = 1. Downstream keeps running. State = FETCH_WAIT.
- Transitions:
  - RUN/FETCH_WAIT → MEM_WAIT on data wait.
  - RUN ↔ FETCH_WAIT on imem_ready.
  - MEM_WAIT → RUN (or FETCH_WAIT) on dmem_ready.
  - Any state → HALT on halt_req, or when the wait counter reaches MEM_TIMEOUT while still waiting.
- Stall and flush are never both 1 for the same register.
- Counters:
  - stall_cnt increments on any cycle with pc_stall = 1.
  - flush_cnt increments on any cycle with if_id_flush or id_ex_flush = 1.
  - Both saturate at all-ones and never wrap.
  - The wait counter is $clog2(MEM_TIMEOUT+1) bits and clears whenever not in MEM_WAIT.

## Timing
- Stall/flush outputs respond in the same cycle as the causing input (zero latency). The targeted registers act on the following clk edge.
- The state register updates on posedge clk; `state` reflects the condition seen in the previous cycle.
- Reset values:
  - state = RUN, halted = 0, counters = 0, wait counter = 0.
  - While reset = 1: all stalls = 0 and all flushes = 1.
- Reset mid-MEM_WAIT or mid-HALT returns to RUN on the next edge; no pending redirect is remembered.
- Timeout: with dmem_ready held low from cycle 0, the wait counter reaches MEM_TIMEOUT at cycle MEM_TIMEOUT−1. state = HALT from cycle MEM_TIMEOUT onward. A dmem_ready that arrives in the timeout cycle wins, and the block goes to RUN.
- Simultaneous halt_req and dmem_ready: HALT.

## Structure
- riscv_pkg additions:
  - hazard_state_t enum (2 bits).
  - pipe_ctrl_t packed struct: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush}.
  - MEM_TIMEOUT_DEFAULT constant.
- One sub-module, hazard_detect: purely combinational load-use compare producing load_use. All remaining logic lives in pipeline_ctrl.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 → one cycle of pc_stall = if_id_stall = id_ex_flush = 1. Next cycle, with ex_mem_read = 0, all outputs = 0. Repeat with ex_rd = 0 → no stall.
- Redirect + load-use in the same cycle: ex_redirect = 1 → if_id_flush = id_ex_flush = 1, pc_stall = 0; flush_cnt += 1.
- Data wait of 3 cycles with ex_redirect held: 3 cycles of all-stall plus mem_wb_flush, state = MEM_WAIT. On the dmem_ready cycle the redirect flush occurs; stall_cnt = 3.
- Fetch wait: imem_ready = 0 for 2 cycles → pc_stall = if_id_flush = 1, id_ex/ex_mem not stalled, state = FETCH_WAIT, then RUN.
- Timeout with MEM_TIMEOUT = 4: dmem_ready held low → halted = 1 after 4 cycles, all stalls = 1. Deassert dmem_req → stays HALT. Pulse reset → RUN, counters = 0.
- Counter saturation with CNT_W = 4: 20 stall cycles → stall_cnt = 15.
